// File: rtl/set_bit_serializer.sv
// set_bit_serializer
// Accepts a request word and drains every set-bit position, one per cycle,
// lowest index first, over valid/ready handshakes on both sides.
// A one-cycle bubble separates consecutive words. An all-zero word produces
// no output and pulses empty_word on the following cycle.
// Optional feature macro: SET_BIT_SER_COUNT_EN adds out_remaining, the
// popcount of the bits still pending while BUSY.
module set_bit_serializer #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
`ifdef SET_BIT_SER_COUNT_EN
  output logic [IDX_W:0]   out_remaining,
`endif
  output logic             empty_word
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] pending_s;
  logic             empty_word_r;
  logic             empty_word_s;
  logic             busy_s;
  logic             last_s;
  logic [IDX_W-1:0] index_s;

  // Position of the lowest set bit; 0 when the word is empty.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [WIDTH-1:0] w);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the word is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] w);
    return (w != {WIDTH{1'b0}}) &&
           ((w & (w - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  endfunction

  // Word with its lowest set bit cleared.
  function automatic logic [WIDTH-1:0] clear_lowest(input logic [WIDTH-1:0] w);
    return w & (w - {{(WIDTH-1){1'b0}}, 1'b1});
  endfunction

`ifdef SET_BIT_SER_COUNT_EN
  // Number of set bits in the word.
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] w);
    logic [IDX_W:0] cnt;
    cnt = {(IDX_W+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, w[i]};
    end
    return cnt;
  endfunction
`endif

  // Decode of the pending register shared by outputs and next-state logic.
  always_comb begin
    busy_s  = (state_r == ST_BUSY);
    index_s = lowest_index(pending_r);
    last_s  = busy_s && is_onehot(pending_r);
  end

  // Next-state logic: load a word in IDLE, retire one bit per transfer in BUSY.
  always_comb begin
    state_s      = state_r;
    pending_s    = pending_r;
    empty_word_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          pending_s = in_word;
          if (in_word != {WIDTH{1'b0}}) begin
            state_s = ST_BUSY;
          end else begin
            empty_word_s = 1'b1;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      ST_BUSY: begin
        if (out_ready) begin
          pending_s = clear_lowest(pending_r);
          if (last_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        pending_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, pending bits and the empty-word pulse; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pending_r    <= {WIDTH{1'b0}};
      empty_word_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      empty_word_r <= empty_word_s;
    end
  end

  // Output decode straight from the registers; in_ready is held low during reset.
  always_comb begin
    in_ready   = (state_r == ST_IDLE) && !rst;
    out_valid  = busy_s;
    out_index  = busy_s ? index_s : {IDX_W{1'b0}};
    out_last   = last_s;
    empty_word = empty_word_r;
`ifdef SET_BIT_SER_COUNT_EN
    out_remaining = busy_s ? popcount(pending_r) : {(IDX_W+1){1'b0}};
`endif
  end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed self-checking bench for set_bit_serializer (WIDTH=4).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_set_bit_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_index;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       empty_word;
`ifdef SET_BIT_SER_COUNT_EN
  logic [2:0] out_remaining;
`endif

  int checks_cnt;
  int errors_cnt;

  set_bit_serializer #(.WIDTH(4), .IDX_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
`ifdef SET_BIT_SER_COUNT_EN
    .out_remaining(out_remaining),
`endif
    .empty_word (empty_word)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One emitted index: valid, index, last flag and (optionally) remaining count.
  task automatic check_emit(input string tag, input int idx, input int last, input int rem);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
`ifdef SET_BIT_SER_COUNT_EN
    check({tag, "_remaining"}, 32'(out_remaining), 32'(rem));
`else
    if (rem < 0) $display("negative remaining count in stimulus");
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef SET_BIT_SER_COUNT_EN
    check({tag, "_remaining"}, 32'(out_remaining), 32'd0);
`endif
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst       = 1'b1;
    in_word   = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_empty", 32'(empty_word), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Word 4'b1100; in_word changes during BUSY must be ignored.
    in_word = 4'b1100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check_emit("w12_a", 2, 0, 2);
    in_word = 4'b0001;
    step();
    check_emit("w12_b", 3, 1, 1);
    in_valid = 1'b0;
    step();
    check_idle("w12_done");

    // All ones: 0,1,2,3 with last only on 3.
    in_word = 4'b1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_emit("w15", i, (i == 3) ? 1 : 0, 4 - i);
      step();
    end
    check_idle("w15_done");

    // Word 4'b0111 with backpressure: index 0 held stable.
    in_word = 4'b0111; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_emit("w7_hold", 0, 0, 3);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_emit("w7", i, (i == 2) ? 1 : 0, 3 - i);
      step();
    end
    check_idle("w7_done");

    // Zero word: no output, one-cycle empty_word pulse.
    in_word = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("zero_empty", 32'(empty_word), 32'd1);
    check_idle("zero_a");
    step();
    check("zero_empty_clr", 32'(empty_word), 32'd0);
    check_idle("zero_b");

    // Reset mid-word, then a top-bit-only word.
    in_word = 4'b1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_emit("midrst_0", 0, 0, 4);
    step();
    check_emit("midrst_1", 1, 0, 3);
    step();
    rst = 1'b1;
    #1;
    check("midrst_in_ready_rst", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_idle("midrst_after");
    check("midrst_index", 32'(out_index), 32'd0);
    in_word = 4'b1000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_emit("w8", 3, 1, 1);
    step();
    check_idle("w8_done");

    // Back-to-back words with in_valid held high: 2,3, bubble, 0,1,2.
    in_word = 4'b1100; in_valid = 1'b1;
    step();
    check_emit("b2b_a", 2, 0, 2);
    in_word = 4'b0111;
    step();
    check_emit("b2b_b", 3, 1, 1);
    step();
    check_idle("b2b_bubble");
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_emit("b2b_w7", i, (i == 2) ? 1 : 0, 3 - i);
      step();
    end
    check_idle("b2b_done");

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
